// File: rtl/mem_bus_responder.sv
// Bus target for the core's native memory bus: byte-writable word RAM with optional
// read wait states, plus an IO page holding LEDs, a cycle counter and a buffered UART.
module mem_bus_responder #(
  parameter int ADDR_WIDTH = 24,
  parameter int RAM_WORDS  = 16384,
  parameter int IO_BIT     = 22,
  parameter int READ_WAIT  = 0,
  parameter int CLK_DIV    = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wmask,
  input  logic        mem_rstrb,
  output logic [31:0] mem_rdata,
  output logic        mem_rbusy,
  output logic        mem_wbusy,
  output logic        uart_tx,
  output logic [7:0]  leds
);

  localparam int RAM_AW = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;
  localparam int DIV_W  = $clog2(CLK_DIV) + 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_ZERO = {DIV_W{1'b0}};
  localparam logic [3:0] WAIT_N = 4'(READ_WAIT);

  localparam logic [2:0] IO_LEDS   = 3'd0;
  localparam logic [2:0] IO_UART   = 3'd1;
  localparam logic [2:0] IO_STATUS = 3'd2;
  localparam logic [2:0] IO_CYCLES = 3'd3;

  typedef enum logic {TX_IDLE = 1'b0, TX_SEND = 1'b1} tx_state_e;

  logic [31:0]       ram_mem [RAM_WORDS];
  logic [RAM_AW-1:0] ram_idx_s;
  logic [31:0]       ram_rd_s, io_rd_s;
  logic [2:0]        io_off_s;
  logic              io_sel_s, wr_s, rd_s, uart_wr_s, stop_end_s, shifter_free_s;
  logic              load_en_s;
  logic [7:0]        load_byte_s;
  logic              unused_s;

  logic [31:0]      rdata_q, rdata_d, pend_q, pend_d, cycles_q, cycles_d;
  logic             rbusy_q, rbusy_d, tx_q, tx_d, hold_full_q, hold_full_d, ovf_q, ovf_d;
  logic [3:0]       wait_q, wait_d, bit_q, bit_d;
  logic [7:0]       leds_q, leds_d, hold_q, hold_d;
  logic [8:0]       shift_q, shift_d;
  logic [DIV_W-1:0] div_q, div_d;
  tx_state_e        tx_state_q, tx_state_d;

  assign unused_s  = ^{mem_addr[31:ADDR_WIDTH], mem_addr[1:0]};
  assign ram_idx_s = RAM_AW'(32'(mem_addr[ADDR_WIDTH-1:2]) % 32'(RAM_WORDS));
  assign ram_rd_s  = ram_mem[ram_idx_s];
  assign io_sel_s  = mem_addr[IO_BIT];
  assign io_off_s  = mem_addr[4:2];
  assign wr_s      = (mem_wmask != 4'b0000);
  assign rd_s      = mem_rstrb;
  assign uart_wr_s = wr_s && io_sel_s && (io_off_s == IO_UART);

  // The shifter is free either when idle or when its stop bit ends with nothing queued behind it.
  assign stop_end_s     = (tx_state_q == TX_SEND) && (div_q == DIV_ZERO) && (bit_q == 4'd0);
  assign shifter_free_s = (tx_state_q == TX_IDLE) || (stop_end_s && !hold_full_q);

  // IO page read mux
  always_comb begin
    case (io_off_s)
      IO_LEDS:   io_rd_s = {24'd0, leds_q};
      IO_STATUS: io_rd_s = {29'd0, hold_full_q, ovf_q, (tx_state_q == TX_SEND)};
      IO_CYCLES: io_rd_s = cycles_q;
      default:   io_rd_s = 32'd0;
    endcase
  end

  // RAM byte-lane writes; contents deliberately survive reset
  always_ff @(posedge clk) begin
    if (reset && wr_s && !io_sel_s) begin
      for (int i = 0; i < 4; i++) begin
        if (mem_wmask[i]) ram_mem[ram_idx_s][8*i +: 8] <= mem_wdata[8*i +: 8];
      end
    end
  end

  // Next-state for the read path, IO registers and UART
  always_comb begin
    rdata_d     = rdata_q;
    pend_d      = pend_q;
    rbusy_d     = rbusy_q;
    wait_d      = wait_q;
    leds_d      = leds_q;
    cycles_d    = cycles_q + 32'd1;
    tx_state_d  = tx_state_q;
    tx_d        = tx_q;
    shift_d     = shift_q;
    bit_d       = bit_q;
    div_d       = div_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    ovf_d       = ovf_q;
    load_en_s   = 1'b0;
    load_byte_s = 8'd0;

    // RAM data is captured at the strobe so a same-cycle write cannot leak into the result.
    if (rd_s) begin
      if (io_sel_s) begin
        rdata_d = io_rd_s;
        rbusy_d = 1'b0;
        wait_d  = 4'd0;
      end else if (WAIT_N == 4'd0) begin
        rdata_d = ram_rd_s;
        rbusy_d = 1'b0;
        wait_d  = 4'd0;
      end else begin
        pend_d  = ram_rd_s;
        rbusy_d = 1'b1;
        wait_d  = WAIT_N;
      end
    end else if (rbusy_q) begin
      if (wait_q <= 4'd1) begin
        rdata_d = pend_q;
        rbusy_d = 1'b0;
        wait_d  = 4'd0;
      end else begin
        wait_d = wait_q - 4'd1;
      end
    end else begin
      wait_d = 4'd0;
    end

    if (wr_s && io_sel_s && (io_off_s == IO_LEDS) && mem_wmask[0]) begin
      leds_d = mem_wdata[7:0];
    end else begin
      leds_d = leds_q;
    end

    if (wr_s && io_sel_s && (io_off_s == IO_STATUS)) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end

    case (tx_state_q)
      TX_IDLE: tx_d = 1'b1;
      TX_SEND: begin
        if (div_q != DIV_ZERO) begin
          div_d = div_q - DIV_W'(1);
        end else if (bit_q != 4'd0) begin
          tx_d    = shift_q[0];
          shift_d = {1'b0, shift_q[8:1]};
          bit_d   = bit_q - 4'd1;
          div_d   = DIV_LAST;
        end else if (hold_full_q) begin
          load_en_s   = 1'b1;
          load_byte_s = hold_q;
          hold_full_d = 1'b0;
        end else begin
          tx_state_d = TX_IDLE;
          tx_d       = 1'b1;
        end
      end
      default: begin
        tx_state_d = TX_IDLE;
        tx_d       = 1'b1;
      end
    endcase

    // A write landing on the holding-to-shifter handoff refills holding without overflowing.
    if (uart_wr_s) begin
      if (shifter_free_s) begin
        load_en_s   = 1'b1;
        load_byte_s = mem_wdata[7:0];
      end else if (!hold_full_q || stop_end_s) begin
        hold_d      = mem_wdata[7:0];
        hold_full_d = 1'b1;
      end else begin
        ovf_d = 1'b1;
      end
    end else begin
      hold_d = hold_q;
    end

    if (load_en_s) begin
      tx_state_d = TX_SEND;
      tx_d       = 1'b0;
      shift_d    = {1'b1, load_byte_s};
      bit_d      = 4'd9;
      div_d      = DIV_LAST;
    end else begin
      shift_d = shift_d;
    end
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      rdata_q     <= 32'd0;
      pend_q      <= 32'd0;
      rbusy_q     <= 1'b0;
      wait_q      <= 4'd0;
      leds_q      <= 8'd0;
      cycles_q    <= 32'd0;
      tx_state_q  <= TX_IDLE;
      tx_q        <= 1'b1;
      shift_q     <= 9'd0;
      bit_q       <= 4'd0;
      div_q       <= DIV_ZERO;
      hold_q      <= 8'd0;
      hold_full_q <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      rdata_q     <= rdata_d;
      pend_q      <= pend_d;
      rbusy_q     <= rbusy_d;
      wait_q      <= wait_d;
      leds_q      <= leds_d;
      cycles_q    <= cycles_d;
      tx_state_q  <= tx_state_d;
      tx_q        <= tx_d;
      shift_q     <= shift_d;
      bit_q       <= bit_d;
      div_q       <= div_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      ovf_q       <= ovf_d;
    end
  end

  assign mem_rdata = rdata_q;
  assign mem_rbusy = rbusy_q;
  assign mem_wbusy = hold_full_q;
  assign uart_tx   = tx_q;
  assign leds      = leds_q;

endmodule

// File: tb/tb_mem_bus_responder.sv
// Scoreboard bench: two responders (zero and three read wait states) share one bus;
// monitors pop expected read data and UART frames as the designs present them.
module tb_mem_bus_responder;

  localparam logic [31:0] IO = 32'h0040_0000;

  typedef struct {
    logic [31:0] data;
    int          busy;
    bit          care;
  } rd_exp_t;

  logic        clk, reset;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wmask;
  logic        mem_rstrb;
  logic [31:0] a_rdata, b_rdata;
  logic        a_rbusy, a_wbusy, a_tx, b_rbusy, b_wbusy, b_tx;
  logic [7:0]  a_leds, b_leds;

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] q_a[$];
  rd_exp_t     q_b[$];
  logic [7:0]  uart_exp[$];
  int          starts_q[$];
  logic [31:0] tb_cyc;
  int          ncyc = 0;
  int          rst_edges = 0;
  logic        rd_seen = 1'b0;
  logic        a_busy_seen = 1'b0;

  mem_bus_responder #(.ADDR_WIDTH(24), .RAM_WORDS(256), .IO_BIT(22), .READ_WAIT(0), .CLK_DIV(4)) dut_a (
    .clk(clk), .reset(reset), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_rstrb(mem_rstrb), .mem_rdata(a_rdata), .mem_rbusy(a_rbusy), .mem_wbusy(a_wbusy),
    .uart_tx(a_tx), .leds(a_leds));

  mem_bus_responder #(.ADDR_WIDTH(24), .RAM_WORDS(256), .IO_BIT(22), .READ_WAIT(3), .CLK_DIV(4)) dut_b (
    .clk(clk), .reset(reset), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_rstrb(mem_rstrb), .mem_rdata(b_rdata), .mem_rbusy(b_rbusy), .mem_wbusy(b_wbusy),
    .uart_tx(b_tx), .leds(b_leds));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) begin
    ncyc      <= ncyc + 1;
    rd_seen   <= mem_rstrb && reset;
    tb_cyc    <= (!reset) ? 32'd0 : tb_cyc + 32'd1;
    rst_edges <= (!reset) ? rst_edges + 1 : rst_edges;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [39:0] frame_bits(input logic [7:0] b);
    logic [39:0] p;
    logic v;
    p = 40'd0;
    for (int j = 0; j < 10; j++) begin
      if (j == 0) v = 1'b0;
      else if (j == 9) v = 1'b1;
      else v = b[j-1];
      for (int k = 0; k < 4; k++) p[j*4+k] = v;
    end
    return p;
  endfunction

  task automatic push_b(input logic [31:0] d, input int busy, input bit care);
    rd_exp_t e;
    e.data = d;
    e.busy = busy;
    e.care = care;
    q_b.push_back(e);
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] mask);
    @(negedge clk);
    mem_addr = addr; mem_wdata = data; mem_wmask = mask; mem_rstrb = 1'b0;
  endtask

  task automatic rd(input logic [31:0] addr, input logic [31:0] exp, input bit to_b, input bit is_cyc);
    @(negedge clk);
    mem_addr = addr; mem_wmask = 4'b0000; mem_rstrb = 1'b1;
    q_a.push_back(is_cyc ? tb_cyc : exp);
    if (to_b) push_b(exp, 3, 1'b1);
  endtask

  task automatic idle();
    @(negedge clk);
    mem_wmask = 4'b0000; mem_rstrb = 1'b0;
  endtask

  task automatic gap(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Zero-wait responder: data due the cycle after each strobe, rbusy must stay low
  initial begin
    logic [31:0] e;
    forever begin
      @(negedge clk);
      if (a_rbusy === 1'b1) a_busy_seen = 1'b1;
      if (rd_seen) begin
        if (q_a.size() == 0) begin
          vectors++; miscompares++;
          $display("FAIL a_resp: got unexpected response 0x%0h, required none", a_rdata);
        end else begin
          e = q_a.pop_front();
          chk("a_rdata", {31'd0, a_rbusy, a_rdata}, {31'd0, 1'b0, e});
        end
      end
    end
  end

  // Wait-state responder: response is taken where rbusy falls; the busy span is checked too
  initial begin
    int bcnt;
    rd_exp_t e;
    bcnt = 0;
    forever begin
      @(negedge clk);
      if (!reset) bcnt = 0;
      else if (b_rbusy === 1'b1) bcnt++;
      else if (bcnt != 0) begin
        if (q_b.size() == 0) begin
          vectors++; miscompares++;
          $display("FAIL b_resp: got unexpected response 0x%0h, required none", b_rdata);
        end else begin
          e = q_b.pop_front();
          chk("b_busy_cycles", 64'(bcnt), 64'(e.busy));
          if (e.care) chk("b_rdata", {32'd0, b_rdata}, {32'd0, e.data});
        end
        bcnt = 0;
      end
    end
  end

  // UART monitor: records 40 samples per frame; frames cut by reset are discarded
  initial begin
    logic [39:0] got;
    logic [7:0]  eb;
    int          r0;
    bit          ab;
    forever begin
      @(negedge clk);
      if (a_tx === 1'b0) begin
        r0 = rst_edges;
        ab = 1'b0;
        starts_q.push_back(ncyc);
        got = 40'd0;
        got[0] = a_tx;
        for (int i = 1; i < 40; i++) begin
          @(negedge clk);
          got[i] = a_tx;
          if (rst_edges != r0) ab = 1'b1;
        end
        if (!ab) begin
          if (uart_exp.size() == 0) begin
            vectors++; miscompares++;
            $display("FAIL uart_frame: got unexpected frame 0x%0h, required none", got);
          end else begin
            eb = uart_exp.pop_front();
            chk("uart_frame", {24'd0, got}, {24'd0, frame_bits(eb)});
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b0; mem_addr = 32'd0; mem_wdata = 32'd0; mem_wmask = 4'b0000; mem_rstrb = 1'b0;
    repeat (3) @(negedge clk);
    chk("a_reset_state", {21'd0, a_rdata, a_rbusy, a_wbusy, a_tx, a_leds}, {21'd0, 32'd0, 1'b0, 1'b0, 1'b1, 8'd0});
    chk("b_reset_state", {21'd0, b_rdata, b_rbusy, b_wbusy, b_tx, b_leds}, {21'd0, 32'd0, 1'b0, 1'b0, 1'b1, 8'd0});
    reset = 1'b1;

    // RAM word write then single byte lane 2
    wr(32'h100, 32'hDEADBEEF, 4'b1111);
    wr(32'h100, 32'h55555555, 4'b0100);
    wr(32'h104, 32'hCAFEF00D, 4'b1111);
    wr(32'h200, 32'h12345678, 4'b1111);
    idle();
    rd(32'h100, 32'hDE55BEEF, 1'b1, 1'b0); idle(); gap(6);

    // Second strobe in wait cycle 2 restarts the countdown with the new address
    rd(32'h100, 32'hDE55BEEF, 1'b0, 1'b0); idle();
    rd(32'h104, 32'hCAFEF00D, 1'b0, 1'b0); idle();
    push_b(32'hCAFEF00D, 5, 1'b1);
    gap(8);

    // Read and write in the same cycle: pre-write data returned
    @(negedge clk);
    mem_addr = 32'h104; mem_wdata = 32'h11111111; mem_wmask = 4'b1111; mem_rstrb = 1'b1;
    q_a.push_back(32'hCAFEF00D);
    push_b(32'd0, 3, 1'b0);
    idle(); gap(6);
    rd(32'h104, 32'h11111111, 1'b1, 1'b0); idle(); gap(6);

    // LEDs and IO read map
    wr(IO, 32'h000000A5, 4'b0001); idle();
    chk("a_leds", {56'd0, a_leds}, {56'd0, 8'hA5});
    chk("b_leds", {56'd0, b_leds}, {56'd0, 8'hA5});
    wr(IO, 32'hFFFFFFFF, 4'b0010); idle();
    chk("leds_lane0_only", {56'd0, a_leds}, {56'd0, 8'hA5});
    rd(IO, 32'h000000A5, 1'b0, 1'b0);
    rd(IO | 32'h4, 32'd0, 1'b0, 1'b0);
    rd(IO | 32'h10, 32'd0, 1'b0, 1'b0);
    rd(IO | 32'h1C, 32'd0, 1'b0, 1'b0);
    idle();
    rd(IO | 32'hC, 32'd0, 1'b0, 1'b1); idle(); gap(8);
    rd(IO | 32'hC, 32'd0, 1'b0, 1'b1); idle(); gap(4);

    // Single UART byte; STATUS busy across exactly 40 cycles
    uart_exp.push_back(8'h55);
    wr(IO | 32'h4, 32'h55555555, 4'b0001); idle();
    rd(IO | 32'h8, 32'd1, 1'b0, 1'b0); idle();
    gap(36);
    rd(IO | 32'h8, 32'd1, 1'b0, 1'b0);
    rd(IO | 32'h8, 32'd0, 1'b0, 1'b0);
    idle(); gap(6);

    // Three back-to-back writes: second buffered, third dropped
    starts_q.delete();
    uart_exp.push_back(8'h41);
    uart_exp.push_back(8'h42);
    wr(IO | 32'h4, 32'h41414141, 4'b0001);
    wr(IO | 32'h4, 32'h42424242, 4'b1000);
    wr(IO | 32'h4, 32'h43434343, 4'b0010);
    idle();
    chk("wbusy_holding", {63'd0, a_wbusy}, {63'd0, 1'b1});
    gap(37);
    chk("wbusy_before_stop_end", {63'd0, a_wbusy}, {63'd0, 1'b1});
    gap(1);
    chk("wbusy_after_stop_end", {63'd0, a_wbusy}, {63'd0, 1'b0});
    gap(45);
    rd(IO | 32'h8, 32'h2, 1'b0, 1'b0); idle();
    chk("frame_count", 64'(starts_q.size()), 64'd2);
    if (starts_q.size() == 2) chk("frame_gap", 64'(starts_q[1] - starts_q[0]), 64'd40);
    wr(IO | 32'h8, 32'd0, 4'b1000); idle();
    rd(IO | 32'h8, 32'd0, 1'b0, 1'b0); idle();

    // Reset in the middle of a frame with a byte held
    wr(IO, 32'h0000003C, 4'b0001);
    wr(IO | 32'h4, 32'h00000099, 4'b0001);
    wr(IO | 32'h4, 32'h00000077, 4'b0001);
    idle(); gap(10);
    @(negedge clk); reset = 1'b0;
    @(negedge clk);
    chk("a_after_reset", {21'd0, a_tx, a_wbusy, a_leds, a_rbusy, a_rdata}, {21'd0, 1'b1, 1'b0, 8'd0, 1'b0, 32'd0});
    chk("b_after_reset", {21'd0, b_tx, b_wbusy, b_leds, b_rbusy, b_rdata}, {21'd0, 1'b1, 1'b0, 8'd0, 1'b0, 32'd0});
    reset = 1'b1;
    gap(2);
    rd(IO | 32'h8, 32'd0, 1'b0, 1'b0); idle();
    rd(32'h200, 32'h12345678, 1'b1, 1'b0); idle(); gap(6);
    rd(32'h100, 32'hDE55BEEF, 1'b1, 1'b0); idle(); gap(50);

    chk("a_queue_drained", 64'(q_a.size()), 64'd0);
    chk("b_queue_drained", 64'(q_b.size()), 64'd0);
    chk("uart_queue_drained", 64'(uart_exp.size()), 64'd0);
    chk("a_rbusy_never_high", {63'd0, a_busy_seen}, {63'd0, 1'b0});

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mem_bus_responder.md
# mem_bus_responder

Target-side responder for the processor's native memory bus (mem_addr/mem_wdata/mem_wmask/mem_rstrb in, mem_rdata/mem_rbusy/mem_wbusy out). It serves a byte-writable word RAM with configurable read wait states, plus a small IO page with an LED register, a free-running cycle counter and a buffered 8N1 UART transmitter. It sits between the core and the board pins and is the only slave on the bus.

## Interface
- ADDR_WIDTH, 24: decoded address bits; bits above are ignored.
- RAM_WORDS, 16384: RAM depth in 32-bit words; index = mem_addr[ADDR_WIDTH-1:2] mod RAM_WORDS.
- IO_BIT, 22: mem_addr[IO_BIT]=1 selects the IO page; 0 selects RAM.
- READ_WAIT, 0: extra rbusy cycles per RAM read (0..15).
- CLK_DIV, 16: clocks per UART bit (≥2).
- clk  in  1  clock; all logic on the rising edge.
- reset  in  1  synchronous, active-low.
- mem_addr  in  32  byte address, valid with rstrb/wmask.
- mem_wdata  in  32  write data, lanes pre-replicated by the core.
- mem_wmask  in  4  byte-lane write enables; nonzero for one cycle = write.
- mem_rstrb  in  1  one-cycle read request.
- mem_rdata  out  32  registered read data.
- mem_rbusy  out  1  read not yet valid.
- mem_wbusy  out  1  write not yet accepted for a follow-up UART write.
- uart_tx  out  1  serial output, idle high.
- leds  out  8  LED register.

## Operation
- Reset (reset=0 at an edge): mem_rdata=0, mem_rbusy=0, mem_wbusy=0, uart_tx=1, leds=0, cycle counter=0, shifter idle, holding register empty, overflow=0. RAM contents are not cleared. Reset mid-frame aborts the frame; uart_tx is 1 the following cycle.
- RAM write: lanes with mem_wmask[i]=1 updated at the edge where wmask is sampled; never raises wbusy.
- RAM read: address captured at the rstrb edge. READ_WAIT=0: rdata valid next cycle, rbusy stays 0. READ_WAIT=N: rbusy=1 for N cycles starting the cycle after rstrb; rdata updates and rbusy falls together. A new rstrb during countdown restarts it with the new address.
- mem_rdata holds its value until the next read completes.
- IO page, word offset mem_addr[4:2]:
  - 0 LEDS: read {24'b0,leds}; write with wmask[0] loads wdata[7:0].
  - 1 UART_DATA: write (any wmask bit) enqueues wdata[7:0]; reads 0.
  - 2 UART_STATUS: read {29'b0, holding_full, overflow, shifter_busy}; any write clears overflow.
  - 3 CYCLES: read-only 32-bit free-running counter, value sampled at the rstrb edge; wraps 0xFFFFFFFF→0.
  - 4..7: read 0, writes ignored.
- IO reads have zero wait states regardless of READ_WAIT.
- UART: shifter idle + write → byte loaded into shifter immediately. Shifter busy, holding empty → byte to holding, holding_full=1. Both full → byte dropped, overflow=1 (sticky).
- mem_wbusy = holding_full.
- Frame: start 0, d0..d7 LSB first, stop 1; each bit CLK_DIV cycles, 10·CLK_DIV per frame. At the end of the stop bit, a full holding register moves into the shifter and its start bit begins the next cycle; holding_full falls the same cycle.
- Simultaneous holding→shifter transfer and a new UART_DATA write: the new byte enters holding; holding_full stays 1; no overflow.
- rstrb and nonzero wmask in the same cycle: the write is performed; the read returns pre-write data.

## Timing
- Read latency: 1 + READ_WAIT cycles from rstrb to rdata valid with rbusy=0.
- Writes complete at the sampling edge. wbusy changes only on UART holding transitions.
- uart_tx falls (start bit) the cycle after the edge that loads the shifter.
- leds update the cycle after the write edge.

## Test plan
- RAM write 0xDEADBEEF at 0x100, then SB 0x55 lane 2 (wmask=0100); read 0x100 with READ_WAIT=0 → rdata=0xDE55BEEF one cycle after rstrb, rbusy never 1.
- READ_WAIT=3: read 0x100 → rbusy=1 for exactly 3 cycles after rstrb, rdata valid as rbusy falls. Second rstrb at wait cycle 2 → countdown restarts.
- Write LEDS=0xA5, read back → leds=0xA5, rdata=0x000000A5. Read CYCLES twice 10 cycles apart → difference 10.
- CLK_DIV=4, write 0x55 → uart_tx: 1 until load, then 0,1,0,1,0,1,0,1,0,1 each held 4 cycles; STATUS bit0=1 for 40 cycles.
- Write 0x41, 0x42, 0x43 back-to-back (third issued while holding full) → wbusy=1 after second write until first stop bit ends; frames 0x41,0x42 contiguous; 0x43 dropped; STATUS=0b010 after idle; any STATUS write clears it.
- Assert reset mid-frame → uart_tx=1, wbusy=0, leds=0, STATUS=0 next cycle; RAM data written before reset reads back unchanged.
